// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared types and elaboration helpers for the digit-serial
//            adder/subtractor: FSM state encoding, digit count and digit
//            counter width calculation, operand width legality check.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must address NDIG digits; a 1-digit configuration still needs a
  // 1-bit counter so the vector is never zero-width.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  // Operand width must split into whole digits.
  function automatic bit width_ok(input int width, input int digit);
    return (digit > 0) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_adder_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_adder
// Purpose  : Combinational DIGIT-bit ripple-carry adder built from full-adder
//            cells. Also exposes the carry into its MSB so the caller can
//            derive two's-complement overflow on the most significant digit.
// Ports    : i_a, i_b [DIGIT] addends; i_ci carry in
//            o_sum [DIGIT] sum; o_co carry out; o_c_msb carry into MSB cell
// Revision : 1.0 - initial release
// ============================================================================
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_co,
  output logic             o_c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_co    = w_c[DIGIT];
  assign o_c_msb = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_adder
// Purpose  : Multi-cycle adder/subtractor processing WIDTH-bit operands
//            DIGIT bits per cycle with a registered inter-digit carry.
//            Valid/ready handshake on both operand and result sides.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready, a, b, ci, sub  - operand side
//            out_valid/out_ready, s, co, ovf   - result side
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int c_NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int c_CNT_W = calc_cnt_w(c_NDIG);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NDIG - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_s;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_co;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [DIGIT-1:0]   w_dig_sum;
  logic               w_dig_co;
  logic               w_dig_cmsb;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [WIDTH-1:0]   w_s_shift;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == c_LAST);

  // Operands are consumed from the LSB end; results enter at the MSB end so
  // that after NDIG shifts the first digit computed sits at bit 0.
  if (DIGIT == WIDTH) begin : g_single
    assign w_a_shift = r_a;
    assign w_b_shift = r_b;
    assign w_s_shift = w_dig_sum;
  end else begin : g_multi
    assign w_a_shift = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_shift = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    assign w_s_shift = {w_dig_sum, r_s[WIDTH-1:DIGIT]};
  end

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .i_a     (r_a[DIGIT-1:0]),
    .i_b     (r_b[DIGIT-1:0]),
    .i_ci    (r_carry),
    .o_sum   (w_dig_sum),
    .o_co    (w_dig_co),
    .o_c_msb (w_dig_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + ~borrow: invert B and the incoming carry once.
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= ci ^ sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= w_a_shift;
      r_b     <= w_b_shift;
      r_s     <= w_s_shift;
      r_carry <= w_dig_co;
      r_cnt   <= r_cnt + c_CNT_W'(1);
      if (w_last) begin
        r_co  <= w_dig_co;
        r_ovf <= w_dig_co ^ w_dig_cmsb;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign co        = r_co;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_adder
// Purpose  : Directed bench for digit_serial_adder in the 32/4 configuration
//            plus a randomised run of the single-cycle 8/8 configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv32, ir32, ci32, sub32, ov32, or32, co32, ovf32;
  logic [31:0] a32, b32, s32;

  logic        iv8, ir8, ci8, sub8, ov8, or8, co8, ovf8;
  logic [7:0]  a8, b8, s8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .ci(ci32), .sub(sub32),
    .out_valid(ov32), .out_ready(or32), .s(s32), .co(co32), .ovf(ovf32)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .ci(ci8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .s(s8), .co(co8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge (block is in IDLE).
  task automatic launch32(input logic [31:0] ta, input logic [31:0] tb_, input logic tci, input logic tsub);
    a32 = ta; b32 = tb_; ci32 = tci; sub32 = tsub; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
  endtask

  // Count cycles after accept until out_valid, bounded.
  task automatic wait32(output int n);
    n = 0;
    while (!ov32 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic release32(input string tag);
    or32 = 1'b1;
    tick();
    or32 = 1'b0;
    chk({tag, "_idle_ready"}, {63'd0, ir32}, 64'd1);
    chk({tag, "_idle_nvalid"}, {63'd0, ov32}, 64'd0);
  endtask

  task automatic op32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tci, input logic tsub,
                      input logic [31:0] es, input logic eco, input logic eovf);
    int n;
    launch32(ta, tb_, tci, tsub);
    wait32(n);
    chk({tag, "_lat"}, 64'(n), 64'd8);
    chk({tag, "_s"}, {32'd0, s32}, {32'd0, es});
    chk({tag, "_co_ovf"}, {62'd0, co32, ovf32}, {62'd0, eco, eovf});
    release32(tag);
  endtask

  initial begin
    int n;
    logic [8:0] r9;
    logic [7:0] ra, rb, rb_eff;
    logic       rci, rsub, rovf;

    rst = 1'b1;
    iv32 = 0; or32 = 0; a32 = '0; b32 = '0; ci32 = 0; sub32 = 0;
    iv8  = 0; or8  = 0; a8  = '0; b8  = '0; ci8  = 0; sub8  = 0;
    tick(); tick();
    rst = 1'b0;

    chk("reset_in_ready", {63'd0, ir32}, 64'd1);
    chk("reset_out_valid", {63'd0, ov32}, 64'd0);
    chk("reset_s_co_ovf", {30'd0, s32, co32, ovf32}, 64'd0);

    op32("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    op32("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op32("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op32("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op32("add_ci",   32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0);
    op32("sub_bin",  32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000E, 1'b1, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    launch32(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    wait32(n);
    chk("bp_lat", 64'(n), 64'd8);
    for (int i = 0; i < 5; i++) begin
      a32 = 32'hDEAD_0000 + 32'(i); b32 = 32'h0BAD_0000; iv32 = 1'b1;
      tick();
      chk("bp_valid_hold", {63'd0, ov32}, 64'd1);
      chk("bp_ready_low", {63'd0, ir32}, 64'd0);
      chk("bp_result_hold", {30'd0, s32, co32, ovf32}, {30'd0, 32'h0000_0030, 2'b00});
    end
    iv32 = 1'b0;
    release32("bp");
    op32("bp_next", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

    // Reset during RUN with three digits done: operation discarded.
    launch32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run_ready", {63'd0, ir32}, 64'd1);
    chk("rst_run_valid", {63'd0, ov32}, 64'd0);
    chk("rst_run_s", {32'd0, s32}, 64'd0);
    op32("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Single-cycle configuration.
    a8 = 8'h7F; b8 = 8'h01; ci8 = 0; sub8 = 0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 20) begin
      tick();
      n++;
    end
    chk("w8_lat", 64'(n), 64'd1);
    chk("w8_first", {54'd0, co8, s8, ovf8}, {54'd0, 1'b0, 8'h80, 1'b1});
    or8 = 1'b1;
    tick();
    or8 = 1'b0;

    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rci = 1'($urandom); rsub = 1'($urandom);
      n = 0;
      while (!ir8 && n < 20) begin
        tick();
        n++;
      end
      a8 = ra; b8 = rb; ci8 = rci; sub8 = rsub; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      n = 0;
      while (!ov8 && n < 20) begin
        tick();
        n++;
      end
      rb_eff = rsub ? ~rb : rb;
      r9 = {1'b0, ra} + {1'b0, rb_eff} + {8'd0, rci ^ rsub};
      rovf = (ra[7] == rb_eff[7]) && (r9[7] != ra[7]);
      for (int st = int'($urandom_range(0, 3)); st > 0; st--) tick();
      chk("w8_rand", {54'd0, co8, s8, ovf8}, {54'd0, r9, rovf});
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
